// File: rtl/seq_updown_modcnt.sv
// Parametrised up/down modulo-N sequence counter with terminal-state detect,
// count enable, synchronous load, wrap pulse and a saturating wrap counter.
module seq_updown_modcnt #(
  parameter int WIDTH   = 2,
  parameter int MODULUS = 4,
  parameter int WRAP_W  = 4,
  parameter int OUT_REG = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              dir,
  input  logic              load,
  input  logic [WIDTH-1:0]  load_val,
  input  logic              clr_wrap,
  output logic [WIDTH-1:0]  count,
  output logic              y,
  output logic              wrap,
  output logic [WRAP_W-1:0] wrap_cnt,
  output logic              load_err
);

  // One extra bit so MODULUS == 2**WIDTH still compares correctly.
  localparam logic [WIDTH:0]    MOD_EXT = (WIDTH+1)'(MODULUS);
  localparam logic [WIDTH-1:0]  LAST    = WIDTH'(MODULUS - 1);
  localparam logic [WRAP_W-1:0] SAT     = '1;
  localparam logic              MOD_TWO = (MODULUS == 2);

  logic [WIDTH-1:0] count_next;
  logic             wrap_next;
  logic             load_err_next;

  always_comb begin
    count_next    = count;
    wrap_next     = 1'b0;
    load_err_next = 1'b0;
    if (load) begin
      if ({1'b0, load_val} < MOD_EXT) begin
        count_next = load_val;
      end else begin
        count_next    = '0;
        load_err_next = 1'b1;
      end
    end else if (en) begin
      // Out-of-range states can only come from upsets; steer them back to 0.
      if ({1'b0, count} >= MOD_EXT) begin
        count_next = '0;
      end else if (!dir) begin
        if (count == LAST) begin
          count_next = '0;
          wrap_next  = 1'b1;
        end else begin
          count_next = count + WIDTH'(1);
          wrap_next  = MOD_TWO;
        end
      end else begin
        if (count == '0) begin
          count_next = LAST;
          wrap_next  = 1'b1;
        end else begin
          count_next = count - WIDTH'(1);
          wrap_next  = MOD_TWO;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count    <= '0;
      wrap     <= 1'b0;
      load_err <= 1'b0;
      wrap_cnt <= '0;
    end else begin
      count    <= count_next;
      wrap     <= wrap_next;
      load_err <= load_err_next;
      if (clr_wrap) begin
        wrap_cnt <= '0;
      end else if (wrap_next && (wrap_cnt != SAT)) begin
        wrap_cnt <= wrap_cnt + WRAP_W'(1);
      end
    end
  end

  // Registering from count_next keeps y aligned with count but glitch-free.
  generate
    if (OUT_REG != 0) begin : g_y_reg
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          y <= 1'b0;
        end else begin
          y <= (count_next == LAST);
        end
      end
    end else begin : g_y_comb
      assign y = (count == LAST);
    end
  endgenerate

endmodule
